// File: rtl/roi_pr_ctrl_if.sv
// Host/ROI/config-engine signal bundle for the partial-reconfiguration controller.
// master: host side, ROI side and config engine (the environment).
// slave:  the controller itself.
interface roi_pr_ctrl_if #(
    parameter int unsigned DIN_N  = 8,
    parameter int unsigned DOUT_N = 8
);
    logic [DIN_N-1:0]  host_din;
    logic [DOUT_N-1:0] host_dout;
    logic [DIN_N-1:0]  roi_din;
    logic [DOUT_N-1:0] roi_dout;
    logic              pr_req;
    logic              pr_ack;
    logic              pr_done;
    logic              decoupled;
    logic              err;
    logic              err_clr;
    logic [7:0]        pr_count;

    modport master (
        output host_din, roi_dout, pr_req, pr_done, err_clr,
        input  host_dout, roi_din, pr_ack, decoupled, err, pr_count
    );

    modport slave (
        input  host_din, roi_dout, pr_req, pr_done, err_clr,
        output host_dout, roi_din, pr_ack, decoupled, err, pr_count
    );
endinterface

// File: rtl/roi_pr_ctrl.sv
// Partial-reconfiguration controller: isolates a reconfigurable region (ROI) from the
// host, hands it to the config engine, and recouples it after a settle period.
// Optional feature: define ROI_PR_TIMEOUT_EN to enable the WAIT_CFG timeout and ERR state;
// without it err is tied low and WAIT_CFG waits indefinitely for pr_done.
module roi_pr_ctrl #(
    parameter int unsigned       DIN_N          = 8,
    parameter int unsigned       DOUT_N         = 8,
    parameter int unsigned       DRAIN_CYCLES   = 4,
    parameter int unsigned       SETTLE_CYCLES  = 16,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DOUT_N-1:0] SAFE_DOUT      = '0
) (
    input logic          clk,
    input logic          rst,
    roi_pr_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StRun, StDrain, StWaitCfg, StErr, StSettle} state_e;

    // Counter reloads hold "cycles remaining minus one" so the exit happens when it hits 0.
    localparam logic [15:0] DrainLoad   = 16'(DRAIN_CYCLES - 1);
    localparam logic [15:0] SettleLoad  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TimeoutLoad = 16'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              inc_count;
    logic              err_d;
    logic [DIN_N-1:0]  roi_din_q;
    logic [DOUT_N-1:0] host_dout_q;
    logic              pr_ack_q;
    logic              decoupled_q;
    logic              err_q;
    logic [7:0]        pr_count_q;

    // Next-state, counter reload/decrement and transaction-complete strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inc_count = 1'b0;
        case (state_q)
            StRun: begin
                if (bus.pr_req) begin
                    state_d = StDrain;
                    cnt_d   = DrainLoad;
                end
            end
            StDrain: begin
                if (!bus.pr_req) begin
                    // Abort before the config engine was ever granted the ROI.
                    state_d = StSettle;
                    cnt_d   = SettleLoad;
                end else if (cnt_q == 16'd0) begin
                    state_d = StWaitCfg;
                    cnt_d   = TimeoutLoad;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StWaitCfg: begin
                if (bus.pr_done) begin
                    state_d   = StSettle;
                    cnt_d     = SettleLoad;
                    inc_count = 1'b1;
                end
`ifdef ROI_PR_TIMEOUT_EN
                else if (cnt_q == 16'd0) begin
                    state_d = StErr;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
`endif
            end
            StErr: begin
                // A late load still counts; err stays until explicitly cleared.
                if (bus.pr_done) begin
                    state_d   = StSettle;
                    cnt_d     = SettleLoad;
                    inc_count = 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == 16'd0) begin
                    state_d = StRun;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 16'd0;
            end
        endcase
    end

`ifdef ROI_PR_TIMEOUT_EN
    // Sticky error: a same-cycle set beats err_clr.
    always_comb begin
        err_d = (state_q == StWaitCfg && state_d == StErr) | (err_q & ~bus.err_clr);
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;

    // Timeout feature absent: err never sets.
    always_comb begin
        err_d = 1'b0;
    end
`endif

    // State, counter and registered outputs; outputs are computed from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            cnt_q       <= 16'd0;
            roi_din_q   <= '0;
            host_dout_q <= '0;
            pr_ack_q    <= 1'b0;
            decoupled_q <= 1'b0;
            err_q       <= 1'b0;
            pr_count_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // ROI input freezes at the last value sampled while coupled.
            if (state_q == StRun) begin
                roi_din_q <= bus.host_din;
            end
            host_dout_q <= (state_d == StRun) ? bus.roi_dout : SAFE_DOUT;
            pr_ack_q    <= (state_d == StWaitCfg);
            decoupled_q <= (state_d != StRun);
            err_q       <= err_d;
            if (inc_count) begin
                pr_count_q <= pr_count_q + 8'd1;
            end
        end
    end

    assign bus.roi_din   = roi_din_q;
    assign bus.host_dout = host_dout_q;
    assign bus.pr_ack    = pr_ack_q;
    assign bus.decoupled = decoupled_q;
    assign bus.err       = err_q;
    assign bus.pr_count  = pr_count_q;

endmodule

// File: tb/tb_roi_pr_ctrl.sv
// Directed testbench for roi_pr_ctrl (default parameters; timeout scenario only when
// ROI_PR_TIMEOUT_EN is defined, where TIMEOUT_CYCLES is set to 8).
module tb_roi_pr_ctrl;

`ifdef ROI_PR_TIMEOUT_EN
    localparam int unsigned Tmo = 8;
`else
    localparam int unsigned Tmo = 1024;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    roi_pr_ctrl_if #(.DIN_N(8), .DOUT_N(8)) bus ();

    roi_pr_ctrl #(
        .DIN_N         (8),
        .DOUT_N        (8),
        .DRAIN_CYCLES  (4),
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(Tmo),
        .SAFE_DOUT     (8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.host_din = 8'hFF;
        bus.roi_dout = 8'hEE;
        bus.pr_req = 1'b0;
        bus.pr_done = 1'b0;
        bus.err_clr = 1'b0;
        #1;
        tick();
        tick();
        checks++; if (bus.roi_din !== 8'h00) begin errors++; $display("FAIL rst_roi_din got %h exp 00", bus.roi_din); end
        checks++; if (bus.host_dout !== 8'h00) begin errors++; $display("FAIL rst_host_dout got %h exp 00", bus.host_dout); end
        checks++; if (bus.pr_ack !== 1'b0) begin errors++; $display("FAIL rst_pr_ack got %b exp 0", bus.pr_ack); end
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL rst_decoupled got %b exp 0", bus.decoupled); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.err); end
        checks++; if (bus.pr_count !== 8'd0) begin errors++; $display("FAIL rst_pr_count got %0d exp 0", bus.pr_count); end
        rst = 1'b0;
        tick();
        checks++; if (bus.roi_din !== 8'hFF) begin errors++; $display("FAIL first_sample_roi_din got %h exp ff", bus.roi_din); end
        checks++; if (bus.host_dout !== 8'hEE) begin errors++; $display("FAIL first_sample_host_dout got %h exp ee", bus.host_dout); end
    endtask

    task automatic test_passthrough();
        bus.host_din = 8'hA5;
        bus.roi_dout = 8'h3C;
        tick();
        checks++; if (bus.roi_din !== 8'hA5) begin errors++; $display("FAIL pass_roi_din got %h exp a5", bus.roi_din); end
        checks++; if (bus.host_dout !== 8'h3C) begin errors++; $display("FAIL pass_host_dout got %h exp 3c", bus.host_dout); end
        bus.host_din = 8'h5A;
        bus.roi_dout = 8'hC3;
        tick();
        checks++; if (bus.roi_din !== 8'h5A) begin errors++; $display("FAIL pass2_roi_din got %h exp 5a", bus.roi_din); end
        checks++; if (bus.host_dout !== 8'hC3) begin errors++; $display("FAIL pass2_host_dout got %h exp c3", bus.host_dout); end
    endtask

    // Cycle numbering: inputs set before edge N, observed values after edge N are cycle N+1.
    task automatic test_full_cycle();
        bus.host_din = 8'h11;
        bus.pr_req = 1'b1;
        tick();  // cycle 1
        checks++; if (bus.decoupled !== 1'b1) begin errors++; $display("FAIL fc_decoupled_c1 got %b exp 1", bus.decoupled); end
        checks++; if (bus.pr_ack !== 1'b0) begin errors++; $display("FAIL fc_pr_ack_c1 got %b exp 0", bus.pr_ack); end
        checks++; if (bus.host_dout !== 8'h00) begin errors++; $display("FAIL fc_safe_dout got %h exp 00", bus.host_dout); end
        checks++; if (bus.roi_din !== 8'h11) begin errors++; $display("FAIL fc_roi_din_c1 got %h exp 11", bus.roi_din); end
        bus.host_din = 8'h22;
        bus.pr_done = 1'b1;  // ignored in DRAIN
        tick();  // cycle 2
        bus.pr_done = 1'b0;
        tick();
        tick();  // cycle 4
        checks++; if (bus.pr_ack !== 1'b0) begin errors++; $display("FAIL fc_pr_ack_c4 got %b exp 0", bus.pr_ack); end
        tick();  // cycle 5
        checks++; if (bus.pr_ack !== 1'b1) begin errors++; $display("FAIL fc_pr_ack_c5 got %b exp 1", bus.pr_ack); end
        bus.pr_req = 1'b0;  // ignored in WAIT_CFG
        repeat (15) tick();  // cycle 20
        checks++; if (bus.pr_ack !== 1'b1) begin errors++; $display("FAIL fc_pr_ack_c20 got %b exp 1", bus.pr_ack); end
        checks++; if (bus.roi_din !== 8'h11) begin errors++; $display("FAIL fc_roi_din_hold got %h exp 11", bus.roi_din); end
        bus.pr_done = 1'b1;
        tick();  // cycle 21
        bus.pr_done = 1'b0;
        checks++; if (bus.pr_ack !== 1'b0) begin errors++; $display("FAIL fc_pr_ack_c21 got %b exp 0", bus.pr_ack); end
        checks++; if (bus.pr_count !== 8'd1) begin errors++; $display("FAIL fc_pr_count got %0d exp 1", bus.pr_count); end
        bus.roi_dout = 8'h3C;
        repeat (15) tick();  // cycle 36
        checks++; if (bus.decoupled !== 1'b1) begin errors++; $display("FAIL fc_decoupled_c36 got %b exp 1", bus.decoupled); end
        checks++; if (bus.host_dout !== 8'h00) begin errors++; $display("FAIL fc_host_dout_c36 got %h exp 00", bus.host_dout); end
        tick();  // cycle 37
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL fc_decoupled_c37 got %b exp 0", bus.decoupled); end
        checks++; if (bus.host_dout !== 8'h3C) begin errors++; $display("FAIL fc_host_dout_c37 got %h exp 3c", bus.host_dout); end
        tick();  // cycle 38
        checks++; if (bus.roi_din !== 8'h22) begin errors++; $display("FAIL fc_roi_din_c38 got %h exp 22", bus.roi_din); end
    endtask

    task automatic test_abort();
        logic ack_seen;
        ack_seen = 1'b0;
        bus.pr_req = 1'b1;
        tick();  // cycle 1
        ack_seen |= bus.pr_ack;
        tick();  // cycle 2
        ack_seen |= bus.pr_ack;
        bus.pr_req = 1'b0;
        tick();  // cycle 3, SETTLE
        ack_seen |= bus.pr_ack;
        for (int i = 0; i < 15; i++) begin
            tick();
            ack_seen |= bus.pr_ack;
        end  // cycle 18
        checks++; if (bus.decoupled !== 1'b1) begin errors++; $display("FAIL abort_decoupled_c18 got %b exp 1", bus.decoupled); end
        tick();  // cycle 19
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL abort_decoupled_c19 got %b exp 0", bus.decoupled); end
        checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL abort_pr_ack got %b exp 0", ack_seen); end
        checks++; if (bus.pr_count !== 8'd1) begin errors++; $display("FAIL abort_pr_count got %0d exp 1", bus.pr_count); end
    endtask

    task automatic test_done_in_run();
        bus.pr_done = 1'b1;
        tick();
        bus.pr_done = 1'b0;
        tick();
        checks++; if (bus.pr_count !== 8'd1) begin errors++; $display("FAIL run_done_pr_count got %0d exp 1", bus.pr_count); end
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL run_done_decoupled got %b exp 0", bus.decoupled); end
    endtask

    task automatic test_back_to_back();
        bus.pr_req = 1'b1;
        repeat (5) tick();  // cycle 5
        checks++; if (bus.pr_ack !== 1'b1) begin errors++; $display("FAIL b2b_pr_ack got %b exp 1", bus.pr_ack); end
        bus.pr_done = 1'b1;
        tick();  // cycle 6, SETTLE
        bus.pr_done = 1'b0;
        repeat (15) tick();  // cycle 21
        checks++; if (bus.decoupled !== 1'b1) begin errors++; $display("FAIL b2b_decoupled_c21 got %b exp 1", bus.decoupled); end
        tick();  // cycle 22, RUN for one cycle
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL b2b_decoupled_c22 got %b exp 0", bus.decoupled); end
        tick();  // cycle 23, DRAIN again
        checks++; if (bus.decoupled !== 1'b1) begin errors++; $display("FAIL b2b_decoupled_c23 got %b exp 1", bus.decoupled); end
        bus.pr_req = 1'b0;
        repeat (17) tick();  // abort -> SETTLE 24..39 -> RUN 40
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL b2b_decoupled_end got %b exp 0", bus.decoupled); end
        checks++; if (bus.pr_count !== 8'd2) begin errors++; $display("FAIL b2b_pr_count got %0d exp 2", bus.pr_count); end
    endtask

    task automatic test_reset_mid_wait();
        bus.pr_req = 1'b1;
        repeat (5) tick();
        checks++; if (bus.pr_ack !== 1'b1) begin errors++; $display("FAIL rmw_pr_ack_pre got %b exp 1", bus.pr_ack); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.pr_ack !== 1'b0) begin errors++; $display("FAIL rmw_pr_ack got %b exp 0", bus.pr_ack); end
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL rmw_decoupled got %b exp 0", bus.decoupled); end
        checks++; if (bus.host_dout !== 8'h00) begin errors++; $display("FAIL rmw_host_dout got %h exp 00", bus.host_dout); end
        checks++; if (bus.pr_count !== 8'd0) begin errors++; $display("FAIL rmw_pr_count got %0d exp 0", bus.pr_count); end
        tick();
        rst = 1'b0;
        bus.pr_req = 1'b0;
        bus.pr_done = 1'b1;  // stale completion must not be honoured
        tick();
        bus.pr_done = 1'b0;
        tick();
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL rmw_post_decoupled got %b exp 0", bus.decoupled); end
        checks++; if (bus.pr_ack !== 1'b0) begin errors++; $display("FAIL rmw_post_pr_ack got %b exp 0", bus.pr_ack); end
        checks++; if (bus.pr_count !== 8'd0) begin errors++; $display("FAIL rmw_post_pr_count got %0d exp 0", bus.pr_count); end
    endtask

`ifdef ROI_PR_TIMEOUT_EN
    task automatic test_timeout();
        bus.pr_req = 1'b1;
        repeat (5) tick();  // cycle 5, WAIT_CFG 5..12
        bus.pr_req = 1'b0;
        repeat (7) tick();  // cycle 12
        checks++; if (bus.pr_ack !== 1'b1) begin errors++; $display("FAIL tmo_pr_ack_c12 got %b exp 1", bus.pr_ack); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL tmo_err_c12 got %b exp 0", bus.err); end
        tick();  // cycle 13, ERR
        checks++; if (bus.pr_ack !== 1'b0) begin errors++; $display("FAIL tmo_pr_ack_c13 got %b exp 0", bus.pr_ack); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL tmo_err_c13 got %b exp 1", bus.err); end
        checks++; if (bus.decoupled !== 1'b1) begin errors++; $display("FAIL tmo_decoupled_c13 got %b exp 1", bus.decoupled); end
        bus.pr_done = 1'b1;
        tick();  // cycle 14, SETTLE
        bus.pr_done = 1'b0;
        checks++; if (bus.pr_count !== 8'd1) begin errors++; $display("FAIL tmo_pr_count got %0d exp 1", bus.pr_count); end
        repeat (16) tick();  // cycle 30, RUN
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL tmo_decoupled_run got %b exp 0", bus.decoupled); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %b exp 1", bus.err); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL tmo_err_clr got %b exp 0", bus.err); end
    endtask
`else
    task automatic test_err_tied();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        tick();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_tied got %b exp 0", bus.err); end
    endtask
`endif

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.pr_req = 1'b1;
            repeat (5) tick();
            bus.pr_req = 1'b0;
            bus.pr_done = 1'b1;
            tick();
            bus.pr_done = 1'b0;
            repeat (16) tick();
            if (i == 254) begin
                checks++; if (bus.pr_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", bus.pr_count); end
            end
        end
        checks++; if (bus.pr_count !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d exp 0", bus.pr_count); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", bus.err); end
        checks++; if (bus.decoupled !== 1'b0) begin errors++; $display("FAIL wrap_decoupled got %b exp 0", bus.decoupled); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_passthrough();
        test_full_cycle();
        test_abort();
        test_done_in_run();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef ROI_PR_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
